// File: rtl/matvec_arbiter.sv
// matvec_arbiter: shares one matvec8 engine among NREQ requesters.
// A requester is granted round-robin and keeps the grant for a whole transaction:
// an optional K*K matrix load plus a K-element vector load, followed by K results.
// Optional build macro: MATVEC_OWNER_CHECK_EN. When defined, a vector-only request
// is eligible only from the requester whose last transaction loaded the matrix.
//
// Ports
//   clk, reset          clock, synchronous active-low reset
//   req_valid/ready     per-requester input handshake
//   req_data            packed input beats, requester i at [i*DW +: DW]
//   req_new_matrix      per-requester "this transaction loads a matrix"
//   mv_input_*          input stream to the engine
//   mv_new_matrix       to engine new_matrix
//   mv_output_*         result stream from the engine
//   rsp_valid/ready     per-requester result handshake (valid is one-hot)
//   rsp_data            shared result bus
//   busy                transaction in progress
//   grant_id            current or last granted requester
//   owner_mismatch      vector-only request from a non-owner (0 without the macro)
module matvec_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned K    = 8,
    parameter int unsigned DW   = 14,
    parameter int unsigned OW   = 28
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*DW-1:0]        req_data,
    input  logic [NREQ-1:0]           req_new_matrix,
    output logic                      mv_input_valid,
    input  logic                      mv_input_ready,
    output logic [DW-1:0]             mv_input_data,
    output logic                      mv_new_matrix,
    input  logic                      mv_output_valid,
    output logic                      mv_output_ready,
    input  logic [OW-1:0]             mv_output_data,
    output logic [NREQ-1:0]           rsp_valid,
    input  logic [NREQ-1:0]           rsp_ready,
    output logic [OW-1:0]             rsp_data,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic [NREQ-1:0]           owner_mismatch
);

    localparam int unsigned GW      = $clog2(NREQ);
    localparam int unsigned TOT_MAT = K * K + K;
    localparam int unsigned CW      = $clog2(K * K + K + 1);
    localparam int unsigned RW      = $clog2(K + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   beat_q, beat_d;
    logic [CW-1:0]   total_q, total_d;
    logic [RW-1:0]   res_q, res_d;

    logic [NREQ-1:0] mismatch_c;
    logic [NREQ-1:0] elig_c;
    logic            found;
    logic [GW-1:0]   pick;
    int unsigned     idx;
    logic            beat;
    logic            res_hs;
    logic [CW-1:0]   total_c;

`ifdef MATVEC_OWNER_CHECK_EN
    logic [GW-1:0]   owner_q, owner_d;
    logic            owner_vld_q, owner_vld_d;

    // Vector-only requests from anyone but the matrix owner are held off.
    always_comb begin
        mismatch_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            mismatch_c[i] = req_valid[i] && !req_new_matrix[i]
                            && (!owner_vld_q || (owner_q != GW'(i)));
        end
    end
`else
    assign mismatch_c = '0;
`endif

    assign elig_c         = req_valid & ~mismatch_c;
    assign owner_mismatch = reset ? mismatch_c : '0;
    assign busy           = reset && (state_q != S_IDLE);
    assign grant_id       = reset ? grant_q : '0;

    // Next-state logic and the combinational engine/requester muxes.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        total_d = total_q;
        res_d   = res_q;
`ifdef MATVEC_OWNER_CHECK_EN
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
`endif
        req_ready       = '0;
        mv_input_valid  = 1'b0;
        mv_input_data   = '0;
        mv_new_matrix   = 1'b0;
        mv_output_ready = 1'b0;
        rsp_valid       = '0;
        rsp_data        = '0;
        found           = 1'b0;
        pick            = grant_q;
        idx             = 0;
        beat            = 1'b0;
        res_hs          = 1'b0;
        total_c         = total_q;

        case (state_q)
            S_IDLE: begin
                // First eligible requester at or after the round-robin pointer.
                for (int unsigned i = 0; i < NREQ; i++) begin
                    idx = 32'(rr_q) + i;
                    if (idx >= NREQ) begin
                        idx = idx - NREQ;
                    end
                    if (!found && elig_c[GW'(idx)]) begin
                        found = 1'b1;
                        pick  = GW'(idx);
                    end
                end
                if (found) begin
                    grant_d = pick;
                    state_d = S_FEED;
                end
            end

            S_FEED: begin
                mv_input_valid     = req_valid[grant_q];
                mv_input_data      = req_data[32'(grant_q) * DW +: DW];
                mv_new_matrix      = req_new_matrix[grant_q];
                req_ready[grant_q] = mv_input_ready;
                beat               = mv_input_valid && mv_input_ready;
                // Transaction length is fixed by new_matrix on the first beat.
                if (beat_q == '0) begin
                    total_c = mv_new_matrix ? CW'(TOT_MAT) : CW'(K);
                end
                if (beat) begin
                    beat_d = beat_q + CW'(1);
                    if (beat_q == '0) begin
                        total_d = total_c;
`ifdef MATVEC_OWNER_CHECK_EN
                        if (mv_new_matrix) begin
                            owner_d     = grant_q;
                            owner_vld_d = 1'b1;
                        end
`endif
                    end
                    if (beat_q == total_c - CW'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                rsp_valid[grant_q] = mv_output_valid;
                rsp_data           = mv_output_data;
                mv_output_ready    = rsp_ready[grant_q];
                res_hs             = mv_output_valid && mv_output_ready;
                if (res_hs) begin
                    res_d = res_q + RW'(1);
                    if (res_q == RW'(K - 1)) begin
                        rr_d    = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
                        beat_d  = '0;
                        total_d = '0;
                        res_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Everything visible is quiet while reset is asserted.
        if (!reset) begin
            req_ready       = '0;
            mv_input_valid  = 1'b0;
            mv_input_data   = '0;
            mv_new_matrix   = 1'b0;
            mv_output_ready = 1'b0;
            rsp_valid       = '0;
            rsp_data        = '0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
            total_q <= '0;
            res_q   <= '0;
`ifdef MATVEC_OWNER_CHECK_EN
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
            total_q <= total_d;
            res_q   <= res_d;
`ifdef MATVEC_OWNER_CHECK_EN
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
`endif
        end
    end

endmodule

// File: tb/tb_matvec_arbiter.sv
// Bench for matvec_arbiter: a behavioural matvec engine, two requester beat
// queues and a scoreboard of expected grant order and result values.
module tb_matvec_arbiter;

    localparam int NREQ = 2;
    localparam int K    = 8;
    localparam int DW   = 14;
    localparam int OW   = 28;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_new_matrix;
    logic               mv_input_valid;
    logic               mv_input_ready;
    logic [DW-1:0]      mv_input_data;
    logic               mv_new_matrix;
    logic               mv_output_valid;
    logic               mv_output_ready;
    logic [OW-1:0]      mv_output_data;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [OW-1:0]      rsp_data;
    logic               busy;
    logic [0:0]         grant_id;
    logic [NREQ-1:0]    owner_mismatch;

    always #5 clk = ~clk;

    matvec_arbiter #(.NREQ(NREQ), .K(K), .DW(DW), .OW(OW)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_data        (req_data),
        .req_new_matrix  (req_new_matrix),
        .mv_input_valid  (mv_input_valid),
        .mv_input_ready  (mv_input_ready),
        .mv_input_data   (mv_input_data),
        .mv_new_matrix   (mv_new_matrix),
        .mv_output_valid (mv_output_valid),
        .mv_output_ready (mv_output_ready),
        .mv_output_data  (mv_output_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .busy            (busy),
        .grant_id        (grant_id),
        .owner_mismatch  (owner_mismatch)
    );

    typedef struct {
        int id;
        int data;
    } rsp_t;

    // Requester beat queues: bit DW is new_matrix, low bits are data.
    logic [DW:0] bq0[$];
    logic [DW:0] bq1[$];
    rsp_t        exp_rsp[$];
    int          exp_order[$];
    int          got[$];

    // Engine model state.
    int ew[K*K];
    int ex[K];
    int ey[K];
    int ecnt, etot, eoi;
    bit eout;

    // Handshakes observed just before the coming edge.
    bit            hs0, hs1, in_hs, out_hs, rst_s;
    logic [DW-1:0] cap_d;
    bit            cap_nm;

    bit              rst_next;
    logic [NREQ-1:0] rsp_rdy_next;
    bit              stall_en;
    int              cyc;
    int              mrem, txn_beats, beats0, beats1;
    int              n_chk, n_pass;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic engine_accept();
        if (ecnt == 0) etot = cap_nm ? K*K+K : K;
        if (etot == K*K+K && ecnt < K*K) ew[ecnt] = int'($signed(cap_d));
        else ex[ecnt - (etot - K)] = int'($signed(cap_d));
        ecnt++;
        if (ecnt == etot) begin
            for (int r = 0; r < K; r++) begin
                ey[r] = 0;
                for (int c = 0; c < K; c++) ey[r] += ew[r*K+c] * ex[c];
            end
            eout = 1'b1;
            eoi  = 0;
            ecnt = 0;
        end
    endtask

    // One clock: update models on the negedge, drive, then sample and check.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!rst_s) begin
            ecnt = 0; eout = 1'b0; eoi = 0; mrem = 0; txn_beats = 0;
        end else begin
            if (in_hs) engine_accept();
            if (out_hs) begin
                eoi++;
                if (eoi == K) eout = 1'b0;
            end
        end
        if (hs0 && bq0.size() > 0) begin void'(bq0.pop_front()); beats0++; end
        if (hs1 && bq1.size() > 0) begin void'(bq1.pop_front()); beats1++; end

        reset     = rst_next;
        rsp_ready = rsp_rdy_next;
        req_valid[0] = bq0.size() > 0;
        req_valid[1] = bq1.size() > 0;
        {req_new_matrix[0], req_data[DW-1:0]}    = (bq0.size() > 0) ? bq0[0] : '0;
        {req_new_matrix[1], req_data[2*DW-1:DW]} = (bq1.size() > 0) ? bq1[0] : '0;
        mv_input_ready  = !eout && !(stall_en && (cyc % 4 == 3));
        mv_output_valid = eout;
        mv_output_data  = eout ? OW'(ey[eoi]) : '0;
        #1;

        rst_s  = reset;
        hs0    = req_valid[0] && req_ready[0];
        hs1    = req_valid[1] && req_ready[1];
        in_hs  = mv_input_valid && mv_input_ready;
        cap_d  = mv_input_data;
        cap_nm = mv_new_matrix;
        out_hs = mv_output_valid && mv_output_ready;

        if (!reset) begin
            chk("reset_outputs_zero",
                longint'({req_ready, mv_input_valid, mv_input_data, mv_new_matrix,
                          mv_output_ready, rsp_valid, rsp_data, busy, grant_id, owner_mismatch}), 0);
        end else begin
            chk("ready_only_granted", req_ready & ~(2'b01 << grant_id), 0);
            if (mv_input_valid) begin
                chk("in_data_pass", mv_input_data, req_data[grant_id*DW +: DW]);
                chk("in_nm_pass", mv_new_matrix, req_new_matrix[grant_id]);
                chk("in_ready_pass", req_ready[grant_id], mv_input_ready);
            end
            if (in_hs) begin
                if (mrem == 0) begin
                    if (exp_order.size() == 0) chk("unexpected_txn", grant_id, 99);
                    else chk("grant_order", grant_id, exp_order.pop_front());
                    mrem = mv_new_matrix ? K*K+K : K;
                    txn_beats = 0;
                end
                mrem--;
                txn_beats++;
            end
            if (rsp_valid != '0) begin
                chk("rsp_valid_onehot", rsp_valid, 2'b01 << grant_id);
                chk("rsp_data_pass", rsp_data, mv_output_data);
            end
            if (out_hs) begin
                got.push_back(int'($signed(rsp_data)));
                if (exp_rsp.size() == 0) chk("unexpected_rsp", rsp_data, -1);
                else begin
                    rsp_t e = exp_rsp.pop_front();
                    chk("rsp_id", grant_id, e.id);
                    chk("rsp_ready_route", rsp_ready[e.id], 1);
                    chk("rsp_value", int'($signed(rsp_data)), e.data);
                end
            end
`ifndef MATVEC_OWNER_CHECK_EN
            chk("owner_mismatch_tied0", owner_mismatch, 0);
`endif
        end
    endtask

    // Queue a transaction: W = wdiag*I (if nm), x[c] = xbase+c, y[r] = yscale*x[r].
    task automatic send(input int id, input bit nm, input int wdiag, input int xbase, input int yscale);
        logic [DW:0] b;
        if (nm) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++) begin
                    b = {1'b1, DW'((r == c) ? wdiag : 0)};
                    if (id == 0) bq0.push_back(b); else bq1.push_back(b);
                end
        end
        for (int c = 0; c < K; c++) begin
            b = {nm, DW'(xbase + c)};
            if (id == 0) bq0.push_back(b); else bq1.push_back(b);
        end
        for (int r = 0; r < K; r++) exp_rsp.push_back('{id: id, data: yscale * (xbase + r)});
    endtask

    task automatic run_until_idle(input string nm, input int budget);
        int n = 0;
        while ((exp_rsp.size() != 0 || exp_order.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk({nm, "_timeout"}, n, -1);
        else chk({nm, "_idle"}, busy, 0);
    endtask

    task automatic do_reset(input int n);
        rst_next = 1'b0;
        bq0.delete(); bq1.delete(); exp_rsp.delete(); exp_order.delete();
        for (int i = 0; i < n; i++) tick();
        rst_next = 1'b1;
    endtask

    initial begin
        int n;
        int hold;
        reset = 1'b0; req_valid = '0; req_data = '0; req_new_matrix = '0; rsp_ready = '0;
        mv_input_ready = 1'b0; mv_output_valid = 1'b0; mv_output_data = '0;
        rsp_rdy_next = 2'b11;
        do_reset(3);

        // Single requester, identity matrix, x = 1..8.
        send(0, 1'b1, 1, 1, 1);
        exp_order.push_back(0);
        beats0 = 0; got.delete();
        tick();
        chk("t1_idle_no_ready", req_ready, 0);
        chk("t1_idle_busy", busy, 0);
        tick();
        chk("t1_feed_busy", busy, 1);
        chk("t1_feed_grant", grant_id, 0);
        chk("t1_feed_valid", mv_input_valid, 1);
        run_until_idle("t1", 400);
        chk("t1_beats", beats0, 72);
        chk("t1_result_count", got.size(), 8);
        if (got.size() == 8)
            for (int i = 0; i < 8; i++) chk("t1_result_literal", got[i], i + 1);

        // Contention after reset, with engine input stalls.
        do_reset(2);
        stall_en = 1'b1;
        send(0, 1'b1, 1, 1, 1);
        send(1, 1'b1, 3, 1, 3);
        exp_order.push_back(0); exp_order.push_back(1);
        run_until_idle("t2a", 600);
        send(0, 1'b1, 2, 5, 2);
        send(1, 1'b1, 1, 5, 1);
        exp_order.push_back(0); exp_order.push_back(1);
        run_until_idle("t2b", 600);
        stall_en = 1'b0;

        // Result back-pressure from requester 0.
        rsp_rdy_next = 2'b10;
        send(0, 1'b1, 1, 10, 1);
        exp_order.push_back(0);
        n = 0;
        while (!mv_output_valid && n < 300) begin tick(); n++; end
        chk("t3_result_pending", mv_output_valid, 1);
        hold = int'(rsp_data);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_out_ready_low", mv_output_ready, 0);
            chk("t3_rsp_data_held", int'(rsp_data), hold);
            chk("t3_rsp_valid", rsp_valid, 2'b01);
            chk("t3_busy", busy, 1);
        end
        rsp_rdy_next = 2'b11;
        run_until_idle("t3", 200);

`ifndef MATVEC_OWNER_CHECK_EN
        // req0 loads 2*I, req1 reuses it with a vector-only request.
        send(0, 1'b1, 2, 1, 2);
        exp_order.push_back(0);
        run_until_idle("t4a", 400);
        got.delete();
        beats1 = 0;
        send(1, 1'b0, 0, 1, 2);
        exp_order.push_back(1);
        run_until_idle("t4b", 200);
        chk("t4_beats", beats1, 8);
        chk("t4_result_count", got.size(), 8);
        if (got.size() == 8)
            for (int i = 0; i < 8; i++) chk("t4_result_literal", got[i], 2 * (i + 1));
`else
        // Owner is req0 (last matrix load); req1 vector-only must be held off.
        beats1 = 0;
        send(0, 1'b1, 1, 1, 1);
        exp_order.push_back(0);
        for (int c = 0; c < K; c++) bq1.push_back({1'b0, DW'(c + 1)});
        tick();
        chk("t6_mismatch", owner_mismatch, 2'b10);
        tick();
        chk("t6_req1_not_ready", req_ready[1], 0);
        chk("t6_req0_granted", grant_id, 0);
        run_until_idle("t6", 400);
        chk("t6_mismatch_after", owner_mismatch, 2'b10);
        chk("t6_req1_no_beats", beats1, 0);
        bq1.delete();
        tick();
        chk("t6_mismatch_clear", owner_mismatch, 0);
`endif

        // Reset in the middle of a matrix load.
        send(0, 1'b1, 1, 1, 1);
        exp_order.push_back(0);
        n = 0;
        while (txn_beats < 30 && n < 200) begin tick(); n++; end
        chk("t5_reached_30", txn_beats, 30);
        rst_next = 1'b0;
        bq0.delete(); exp_rsp.delete(); exp_order.delete();
        tick();
        tick();
        chk("t5_busy", busy, 0);
        chk("t5_grant", grant_id, 0);
        chk("t5_ready_valid", longint'({req_ready, mv_input_valid, mv_output_ready, rsp_valid}), 0);
        rst_next = 1'b1;
        tick();
        send(1, 1'b1, 3, 2, 3);
        exp_order.push_back(1);
        run_until_idle("t5_recover", 400);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
